// File: rtl/tz_time_converter.sv
// rtl/tz_time_converter.sv - local time to selected time-zone time converter
module tz_time_converter (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Hours,
  input  logic [5:0] Minutes,
  input  logic [6:0] TZHours,
  input  logic [5:0] TZMinutes,
  input  logic       TZPlusMinus,
  output logic [4:0] ZoneHours,
  output logic [5:0] ZoneMinutes,
  output logic [1:0] DayOffset,
  output logic       Valid,
  output logic       Update
);

  typedef enum logic [1:0] {IDLE, MIN, HOUR, COMMIT} state_t;

  state_t state;

  // Unsanitised copy of the last capture, used only for change detection
  logic [4:0] raw_hours;
  logic [5:0] raw_minutes;
  logic [6:0] raw_tz_hours;
  logic [5:0] raw_tz_minutes;
  logic       raw_plus;

  // Sanitised snapshot the computation runs on
  logic [4:0] snap_hours;
  logic [5:0] snap_minutes;
  logic [3:0] snap_tz_hours;
  logic [5:0] snap_tz_minutes;
  logic       snap_plus;
  logic       snap_ok;

  // Intermediate results; carry doubles as borrow on the minus path
  logic [5:0] m_res;
  logic [4:0] h_res;
  logic       carry;
  logic [1:0] day;

  logic       changed;
  logic [4:0] san_hours;
  logic [5:0] san_minutes;
  logic [3:0] san_tz_hours;
  logic [5:0] san_tz_minutes;
  logic [6:0] min_sum;
  logic [6:0] min_diff;
  logic [6:0] min_diff_wrap;
  logic [5:0] hour_sum;
  logic [5:0] hour_diff;
  logic [5:0] hour_diff_wrap;

  // Change detection, input clamping and the minute/hour arithmetic
  always_comb begin
    changed = (Hours != raw_hours) || (Minutes != raw_minutes) ||
              (TZHours != raw_tz_hours) || (TZMinutes != raw_tz_minutes) ||
              (TZPlusMinus != raw_plus);

    san_hours      = (Hours > 5'd23)     ? 5'd23 : Hours;
    san_minutes    = (Minutes > 6'd59)   ? 6'd59 : Minutes;
    san_tz_hours   = (TZHours > 7'd12)   ? 4'd12 : TZHours[3:0];
    san_tz_minutes = (TZMinutes > 6'd59) ? 6'd59 : TZMinutes;

    // Minus path uses two's complement; bit 6 set means the result went negative
    min_sum       = {1'b0, snap_minutes} + {1'b0, snap_tz_minutes};
    min_diff      = {1'b0, snap_minutes} - {1'b0, snap_tz_minutes};
    min_diff_wrap = min_diff + 7'd60;

    // Hour range is -13..36, so 6 bits suffice for both directions
    hour_sum       = {1'b0, snap_hours} + {2'b00, snap_tz_hours} + {5'd0, carry};
    hour_diff      = {1'b0, snap_hours} - {2'b00, snap_tz_hours} - {5'd0, carry};
    hour_diff_wrap = hour_diff + 6'd24;
  end

  // Conversion FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      snap_ok         <= 1'b0;
      raw_hours       <= 5'd0;
      raw_minutes     <= 6'd0;
      raw_tz_hours    <= 7'd0;
      raw_tz_minutes  <= 6'd0;
      raw_plus        <= 1'b0;
      snap_hours      <= 5'd0;
      snap_minutes    <= 6'd0;
      snap_tz_hours   <= 4'd0;
      snap_tz_minutes <= 6'd0;
      snap_plus       <= 1'b0;
      m_res           <= 6'd0;
      h_res           <= 5'd0;
      carry           <= 1'b0;
      day             <= 2'b00;
      ZoneHours       <= 5'd0;
      ZoneMinutes     <= 6'd0;
      DayOffset       <= 2'b00;
      Valid           <= 1'b0;
      Update          <= 1'b0;
    end else begin
      Update <= 1'b0;
      case (state)
        IDLE: begin
          if (!snap_ok || changed) begin
            raw_hours       <= Hours;
            raw_minutes     <= Minutes;
            raw_tz_hours    <= TZHours;
            raw_tz_minutes  <= TZMinutes;
            raw_plus        <= TZPlusMinus;
            snap_hours      <= san_hours;
            snap_minutes    <= san_minutes;
            snap_tz_hours   <= san_tz_hours;
            snap_tz_minutes <= san_tz_minutes;
            snap_plus       <= TZPlusMinus;
            snap_ok         <= 1'b1;
            Valid           <= 1'b0;
            state           <= MIN;
          end
        end
        MIN: begin
          if (snap_plus) begin
            if (min_sum >= 7'd60) begin
              m_res <= 6'(min_sum - 7'd60);
              carry <= 1'b1;
            end else begin
              m_res <= min_sum[5:0];
              carry <= 1'b0;
            end
          end else begin
            if (min_diff[6]) begin
              m_res <= min_diff_wrap[5:0];
              carry <= 1'b1;
            end else begin
              m_res <= min_diff[5:0];
              carry <= 1'b0;
            end
          end
          state <= HOUR;
        end
        HOUR: begin
          if (snap_plus) begin
            if (hour_sum >= 6'd24) begin
              h_res <= 5'(hour_sum - 6'd24);
              day   <= 2'b01;
            end else begin
              h_res <= hour_sum[4:0];
              day   <= 2'b00;
            end
          end else begin
            if (hour_diff[5]) begin
              h_res <= hour_diff_wrap[4:0];
              day   <= 2'b10;
            end else begin
              h_res <= hour_diff[4:0];
              day   <= 2'b00;
            end
          end
          state <= COMMIT;
        end
        COMMIT: begin
          ZoneHours   <= h_res;
          ZoneMinutes <= m_res;
          DayOffset   <= day;
          Valid       <= 1'b1;
          Update      <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tz_time_converter.sv
// tb/tb_tz_time_converter.sv - self-checking bench for tz_time_converter
module tb_tz_time_converter;

  logic       clk;
  logic       reset;
  logic [4:0] Hours;
  logic [5:0] Minutes;
  logic [6:0] TZHours;
  logic [5:0] TZMinutes;
  logic       TZPlusMinus;
  logic [4:0] ZoneHours;
  logic [5:0] ZoneMinutes;
  logic [1:0] DayOffset;
  logic       Valid;
  logic       Update;

  int checks = 0;
  int errors = 0;

  tz_time_converter dut (
    .clk(clk),
    .reset(reset),
    .Hours(Hours),
    .Minutes(Minutes),
    .TZHours(TZHours),
    .TZMinutes(TZMinutes),
    .TZPlusMinus(TZPlusMinus),
    .ZoneHours(ZoneHours),
    .ZoneMinutes(ZoneMinutes),
    .DayOffset(DayOffset),
    .Valid(Valid),
    .Update(Update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole-day minute arithmetic on clamped inputs
  function automatic logic [12:0] model(input int h, input int m, input int tzh,
                                        input int tzm, input int plus);
    int t;
    int d;
    if (h > 23) h = 23;
    if (m > 59) m = 59;
    if (tzh > 12) tzh = 12;
    if (tzm > 59) tzm = 59;
    t = plus ? (h * 60 + m) + (tzh * 60 + tzm) : (h * 60 + m) - (tzh * 60 + tzm);
    d = 0;
    if (t >= 1440) begin t = t - 1440; d = 1; end
    else if (t < 0) begin t = t + 1440; d = 2; end
    return {d[1:0], 5'(t / 60), 6'(t % 60)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int h, input int m, input int tzh, input int tzm, input int p);
    Hours       = 5'(h);
    Minutes     = 6'(m);
    TZHours     = 7'(tzh);
    TZMinutes   = 6'(tzm);
    TZPlusMinus = p[0];
  endtask

  // Drive inputs and follow one full 4-edge pass from capture to commit
  task automatic do_pass(input string tag, input int h, input int m, input int tzh,
                         input int tzm, input int p);
    logic [12:0] exp;
    exp = model(h, m, tzh, tzm, p);
    drive(h, m, tzh, tzm, p);
    tick();
    check({tag, "_capture_valid"}, Valid, 0);
    tick();
    tick();
    check({tag, "_pre_commit_update"}, Update, 0);
    tick();
    check({tag, "_result"}, {DayOffset, ZoneHours, ZoneMinutes}, exp);
    check({tag, "_valid"}, Valid, 1);
    check({tag, "_update"}, Update, 1);
    tick();
    check({tag, "_update_drop"}, Update, 0);
  endtask

  initial begin
    int rh, rm, rtzh, rtzm, rp;
    logic [12:0] exp;

    reset = 1'b1;
    drive(0, 0, 0, 0, 1);
    tick();
    check("reset_hours", ZoneHours, 0);
    check("reset_minutes", ZoneMinutes, 0);
    check("reset_day", DayOffset, 0);
    check("reset_valid", Valid, 0);
    check("reset_update", Update, 0);

    reset = 1'b0;
    do_pass("basic", 10, 20, 7, 0, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("stable_valid", Valid, 1);
      check("stable_update", Update, 0);
    end

    do_pass("plus_wrap", 23, 50, 12, 30, 1);
    do_pass("minus_wrap", 0, 10, 12, 45, 0);
    do_pass("identity_minus", 5, 0, 0, 0, 0);
    do_pass("clamp", 30, 63, 13, 0, 1);

    // Change TZHours while the pass is in MIN; first commit keeps the old value
    drive(10, 20, 7, 0, 1);
    tick();
    TZHours = 7'd8;
    tick();
    tick();
    tick();
    check("midpass_first", {DayOffset, ZoneHours, ZoneMinutes}, model(10, 20, 7, 0, 1));
    check("midpass_first_valid", Valid, 1);
    tick();
    check("midpass_valid_drop", Valid, 0);
    tick();
    tick();
    tick();
    check("midpass_second", {DayOffset, ZoneHours, ZoneMinutes}, model(10, 20, 8, 0, 1));
    check("midpass_second_valid", Valid, 1);
    check("midpass_second_update", Update, 1);
    tick();

    // Reset while in HOUR aborts the pass
    drive(3, 15, 4, 30, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("abort_result", {DayOffset, ZoneHours, ZoneMinutes}, 0);
    check("abort_valid", Valid, 0);
    check("abort_update", Update, 0);
    reset = 1'b0;
    do_pass("after_abort", 3, 15, 4, 30, 0);

    // Randomized passes over the full input ranges, including out-of-range values
    rh = 3; rm = 15; rtzh = 4; rtzm = 30; rp = 0;
    for (int i = 0; i < 40; i++) begin
      int nh, nm, ntzh, ntzm, np;
      nh   = int'($urandom_range(0, 31));
      nm   = int'($urandom_range(0, 63));
      ntzh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 12));
      ntzm = int'($urandom_range(0, 63));
      np   = int'($urandom_range(0, 1));
      if (nh == rh && nm == rm && ntzh == rtzh && ntzm == rtzm && np == rp) np = 1 - np;
      do_pass("random", nh, nm, ntzh, ntzm, np);
      rh = nh; rm = nm; rtzh = ntzh; rtzm = ntzm; rp = np;
    end

    // Output holds with stable inputs after the random run
    exp = model(rh, rm, rtzh, rtzm, rp);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("final_hold", {DayOffset, ZoneHours, ZoneMinutes}, exp);
      check("final_update", Update, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
